// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file.
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_REGS : default geometry of the block
//   state_t                                : frame state machine encoding
package spi_regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 7;
    localparam int DEF_NUM_REGS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_regfile_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, loads RST_VAL into both flops
//   d    : asynchronous input
//   q    : synchronised output
// Parameter RST_VAL: idle level of the input, used so that reset does not
// manufacture a spurious edge on the synchronised signal.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= RST_VAL;
            q_reg    <= RST_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/spi_regfile.sv
// SPI (mode 0) slave register file. Frames are rw, addr, data, MSB first.
// A complete write frame to a legal address updates one register and pulses
// wr_pulse; a malformed or out-of-range write frame pulses err_pulse.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   sclk, sdi, ncs  : asynchronous SPI inputs (synchronised internally)
//   sdo             : SPI data out, always driven
//   regs            : flattened registers, register i at [i*DATA_W +: DATA_W]
//   wr_pulse/wr_addr: one-cycle commit strobe and its address
//   err_pulse       : one-cycle strobe for a rejected write frame
// Optional feature: define SPI_REGFILE_READBACK_EN to return regs[addr] on
// sdo during a read frame; otherwise sdo is tied low and reads are ignored.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       sdi,
    input  logic                       ncs,
    output logic                       sdo,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       err_pulse
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    // rw is held separately, so the shifter only keeps addr+data
    localparam int SH_W    = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic sclk_s, sdi_s, ncs_s;

    sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_sdi  (.clk(clk), .rst(rst), .d(sdi),  .q(sdi_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst(rst), .d(ncs),  .q(ncs_s));

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [SH_W-1:0]     shift_reg, shift_next;
    logic                rw_reg, rw_next;
    logic                sclk_prev_reg;
    logic                ncs_prev_reg;
    logic [1:0]          settle_reg;
    logic                armed_reg;
    logic                wr_pulse_reg, err_pulse_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [DATA_W-1:0]   regs_reg [NUM_REGS];

    logic                ncs_fall, ncs_rise, sclk_rise;
    logic                commit_wr, commit_err;
    logic [ADDR_W-1:0]   addr_f;
    logic [DATA_W-1:0]   data_f;
    logic                addr_ok;

    // The synchroniser outputs only reflect the pins two cycles after reset.
    // A frame may start only once ncs_s has been seen high after that, so an
    // ncs held low across reset cannot open a frame mid-way through its bits.
    assign ncs_fall  = armed_reg & ncs_prev_reg & ~ncs_s;
    assign ncs_rise  = ~ncs_prev_reg & ncs_s;
    assign sclk_rise = ~sclk_prev_reg & sclk_s;

    assign addr_f  = shift_reg[DATA_W +: ADDR_W];
    assign data_f  = shift_reg[DATA_W-1:0];
    assign addr_ok = (int'(addr_f) < NUM_REGS);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        rw_next    = rw_reg;
        commit_wr  = 1'b0;
        commit_err = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (ncs_fall) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    shift_next = '0;
                    rw_next    = 1'b0;
                end
            end
            SHIFT: begin
                // ncs edge wins over a coincident sclk edge
                if (ncs_rise) begin
                    state_next = COMMIT;
                end else if (sclk_rise) begin
                    shift_next = {shift_reg[SH_W-2:0], sdi_s};
                    if (cnt_reg == '0) begin
                        rw_next = sdi_s;
                    end
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
                // rw_reg is 0 for an empty frame, so it never pulses
                if (rw_reg) begin
                    if ((cnt_reg == CNT_FULL) && addr_ok) begin
                        commit_wr = 1'b1;
                    end else begin
                        commit_err = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            rw_reg        <= 1'b0;
            sclk_prev_reg <= 1'b0;
            ncs_prev_reg  <= 1'b1;
            settle_reg    <= 2'b00;
            armed_reg     <= 1'b0;
            wr_pulse_reg  <= 1'b0;
            err_pulse_reg <= 1'b0;
            wr_addr_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            rw_reg        <= rw_next;
            sclk_prev_reg <= sclk_s;
            ncs_prev_reg  <= ncs_s;
            settle_reg    <= {settle_reg[0], 1'b1};
            if (settle_reg[1] && ncs_s) begin
                armed_reg <= 1'b1;
            end
            wr_pulse_reg  <= commit_wr;
            err_pulse_reg <= commit_err;
            if (commit_wr) begin
                wr_addr_reg <= addr_f;
            end
        end
    end

    // Register update lands on the same edge that raises wr_pulse
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_reg[i] <= '0;
            end else if (commit_wr && (addr_f == ADDR_W'(i))) begin
                regs_reg[i] <= data_f;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

    assign wr_pulse  = wr_pulse_reg;
    assign err_pulse = err_pulse_reg;
    assign wr_addr   = wr_addr_reg;

`ifdef SPI_REGFILE_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_ADDR1 = CNT_W'(ADDR_W + 1);

    logic [DATA_W-1:0] out_shift_reg;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              sclk_fall;

    assign sclk_fall = sclk_prev_reg & ~sclk_s;
    // address as it stands once the current sclk rise has been shifted in
    assign rd_addr   = shift_next[ADDR_W-1:0];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = regs_reg[i];
            end
        end
    end

    // Load on the rise that completes the address; the fall right after that
    // rise is skipped so the MSB is still on sdo when the master samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_shift_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (ncs_fall) begin
                out_shift_reg <= '0;
            end
        end else if ((state_reg == SHIFT) && !ncs_rise) begin
            if (sclk_rise && (cnt_reg == CNT_ADDR) && !rw_reg) begin
                out_shift_reg <= rd_data;
            end else if (sclk_fall && (cnt_reg > CNT_ADDR1)) begin
                out_shift_reg <= {out_shift_reg[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign sdo = (state_reg == SHIFT) & ~rst & out_shift_reg[DATA_W-1];
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile (default geometry 8/7/5).
// Stimulus tasks push the expected strobe (kind, address, full register
// image) into a queue; an independent monitor pops and compares whenever
// wr_pulse or err_pulse is seen.
module tb_spi_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, sdi, ncs;
    logic        sdo;
    logic [39:0] regs;
    logic        wr_pulse;
    logic [6:0]  wr_addr;
    logic        err_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [6:0]  addr;
        logic [39:0] regs_v;
    } exp_t;

    exp_t exp_q[$];

    spi_regfile #(.DATA_W(8), .ADDR_W(7), .NUM_REGS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .sdi       (sdi),
        .ncs       (ncs),
        .sdo       (sdo),
        .regs      (regs),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit is_err, input logic [6:0] addr, input logic [39:0] rv);
        exp_t e;
        e.is_err = is_err;
        e.addr   = addr;
        e.regs_v = rv;
        exp_q.push_back(e);
    endtask

    task automatic spi_begin();
        ncs = 1'b0;
        clks(6);
    endtask

    // one mode-0 bit; sdo is sampled just before the rising edge
    task automatic spi_bit(input logic b, output logic so);
        sdi = b;
        clks(4);
        so = sdo;
        sclk = 1'b1;
        clks(8);
        sclk = 1'b0;
        clks(4);
    endtask

    task automatic spi_end(input int gap);
        ncs = 1'b1;
        clks(gap);
    endtask

    task automatic send(input logic [15:0] frame, input int nbits, input int gap);
        logic so;
        spi_begin();
        for (int i = 0; i < nbits; i++) spi_bit(frame[15-i], so);
        spi_end(gap);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            clks(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected strobes never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (!rst && (wr_pulse || err_pulse)) begin
            exp_t e;
            if (wr_pulse && err_pulse) chk("both_strobes", 64'd1, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {62'd0, wr_pulse, err_pulse}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {63'd0, err_pulse}, {63'd0, e.is_err});
                if (!e.is_err) chk("wr_addr", {57'd0, wr_addr}, {57'd0, e.addr});
                chk("regs_at_strobe", {24'd0, regs}, {24'd0, e.regs_v});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       so;
        rst = 1'b1; sclk = 1'b0; sdi = 1'b0; ncs = 1'b1;
        clks(5);
        chk("rst_regs",      {24'd0, regs},      64'd0);
        chk("rst_sdo",       {63'd0, sdo},       64'd0);
        chk("rst_wr_pulse",  {63'd0, wr_pulse},  64'd0);
        chk("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
        chk("rst_wr_addr",   {57'd0, wr_addr},   64'd0);
        rst = 1'b0;
        clks(5);

        // write addr 1 data 0x55
        push_exp(1'b0, 7'd1, 40'h00_00_00_55_00);
        send(16'h8155, 16, 10);
        drain("wr_addr1");

        // write to addr 5 is out of range with 5 registers
        push_exp(1'b1, 7'd0, 40'h00_00_00_55_00);
        send(16'h85AA, 16, 10);
        drain("err_addr5");

        // truncated write frame (12 bits)
        push_exp(1'b1, 7'd0, 40'h00_00_00_55_00);
        send(16'h8233, 12, 10);
        drain("err_trunc");
        chk("trunc_reg2", {56'd0, regs[23:16]}, 64'd0);

        // empty frame and a read-type frame: no strobe at all
        send(16'h0000, 0, 10);
        send(16'h0199, 16, 10);
        clks(20);
        chk("empty_rd_regs", {24'd0, regs}, {24'd0, 40'h00_00_00_55_00});

        // back-to-back writes, 2 clk of ncs high between them
        push_exp(1'b0, 7'd0, 40'h00_00_00_55_11);
        push_exp(1'b0, 7'd0, 40'h00_00_00_55_22);
        send(16'h8011, 16, 2);
        send(16'h8022, 16, 10);
        drain("b2b");
        chk("b2b_reg0", {56'd0, regs[7:0]}, 64'h22);

        // write addr 3, then read it back
        push_exp(1'b0, 7'd3, 40'h00_42_00_55_22);
        send(16'h8342, 16, 10);
        drain("wr_addr3");
        rd = 8'h00;
        spi_begin();
        for (int i = 0; i < 16; i++) begin
            spi_bit(((16'h0300 >> (15 - i)) & 16'h1) != 16'h0, so);
            if (i >= 8) rd = {rd[6:0], so};
        end
        spi_end(10);
`ifdef SPI_REGFILE_READBACK_EN
        chk("readback_addr3", {56'd0, rd}, 64'h42);
`else
        chk("sdo_tied_low", {56'd0, rd}, 64'h00);
`endif

        // reset after 10 bits of a write to addr 2 with ncs held low
        spi_begin();
        for (int i = 0; i < 10; i++) spi_bit(((16'h82FF >> (15 - i)) & 16'h1) != 16'h0, so);
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        for (int i = 10; i < 16; i++) spi_bit(((16'h82FF >> (15 - i)) & 16'h1) != 16'h0, so);
        spi_end(20);
        chk("midreset_regs", {24'd0, regs}, 64'd0);

        // recovery: write the highest legal address
        push_exp(1'b0, 7'd4, 40'h77_00_00_00_00);
        send(16'h8477, 16, 10);
        drain("wr_addr4");

        clks(10);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
